// File: rtl/spike_rate_decoder.sv
// Rate-coded readout for a spiking output layer: counts spikes per lane over a fixed window,
// then scans the lanes sequentially to report the most active one.
module spike_rate_decoder #(
    parameter int unsigned NUM_OUTPUTS = 2,
    parameter int unsigned WINDOW      = 16,
    parameter int unsigned CNT_W       = 8,
    localparam int unsigned IW         = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_OUTPUTS-1:0]       spikes,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         result_ready,
    output logic                         busy,
    output logic                         result_valid,
    output logic [IW-1:0]                winner,
    output logic [CNT_W-1:0]             winner_count,
    output logic                         no_spike,
    output logic [NUM_OUTPUTS*CNT_W-1:0] counts
);

    localparam int unsigned      SW       = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [SW-1:0]    LastStep = SW'(WINDOW - 1);
    localparam logic [IW-1:0]    LastLane = IW'(NUM_OUTPUTS - 1);
    localparam logic [CNT_W-1:0] CntMax   = '1;

    typedef enum logic [1:0] {StIdle, StCount, StScan, StDone} state_e;

    state_e                              state_q, state_d;
    logic [NUM_OUTPUTS-1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]                       step_q, step_d;
    logic [IW-1:0]                       idx_q, idx_d;
    logic [IW-1:0]                       best_idx_q, best_idx_d;
    logic [CNT_W-1:0]                    best_cnt_q, best_cnt_d;
    logic [IW-1:0]                       win_q, win_d;
    logic [CNT_W-1:0]                    wc_q, wc_d;
    logic                                ns_q, ns_d;

    logic [CNT_W-1:0]                    lane_cnt;
    logic [IW-1:0]                       scan_idx;
    logic [CNT_W-1:0]                    scan_cnt;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        step_d     = step_q;
        idx_d      = idx_q;
        best_idx_d = best_idx_q;
        best_cnt_d = best_cnt_q;
        win_d      = win_q;
        wc_d       = wc_q;
        ns_d       = ns_q;
        lane_cnt   = cnt_q[idx_q];
        // Strict compare keeps the earliest lane on ties.
        scan_idx   = (lane_cnt > best_cnt_q) ? idx_q : best_idx_q;
        scan_cnt   = (lane_cnt > best_cnt_q) ? lane_cnt : best_cnt_q;

        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        cnt_d   = '0;
                        step_d  = '0;
                        win_d   = '0;
                        wc_d    = '0;
                        ns_d    = 1'b0;
                        state_d = StCount;
                    end
                end
                StCount: begin
                    for (int i = 0; i < NUM_OUTPUTS; i++) begin
                        if (spikes[i] && (cnt_q[i] != CntMax)) begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    step_d = step_q + SW'(1);
                    if (step_q == LastStep) begin
                        idx_d      = '0;
                        best_idx_d = '0;
                        best_cnt_d = '0;
                        state_d    = StScan;
                    end
                end
                StScan: begin
                    best_idx_d = scan_idx;
                    best_cnt_d = scan_cnt;
                    idx_d      = idx_q + IW'(1);
                    if (idx_q == LastLane) begin
                        win_d   = scan_idx;
                        wc_d    = scan_cnt;
                        ns_d    = (scan_cnt == '0);
                        state_d = StDone;
                    end
                end
                StDone: begin
                    if (result_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            step_q     <= '0;
            idx_q      <= '0;
            best_idx_q <= '0;
            best_cnt_q <= '0;
            win_q      <= '0;
            wc_q       <= '0;
            ns_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            step_q     <= step_d;
            idx_q      <= idx_d;
            best_idx_q <= best_idx_d;
            best_cnt_q <= best_cnt_d;
            win_q      <= win_d;
            wc_q       <= wc_d;
            ns_q       <= ns_d;
        end
    end

    assign busy         = (state_q != StIdle);
    assign result_valid = (state_q == StDone);
    assign winner       = win_q;
    assign winner_count = wc_q;
    assign no_spike     = ns_q;
    assign counts       = cnt_q;

endmodule
